spi_reg_slave: RTL and testbench

- SPI responder front end for the motor-controller register file.
- Receives the 16-clock, two-byte transaction the host drives. Byte 0 is the command {rw, addr[3:0], 3'b000}; byte 1 is the data, MSB first.
- Converts each transaction into single-cycle register read or write strobes in the clk domain.
- For reads, shifts the register value back on miso. It sits between the SPI pins and the register/watchdog/PWM logic inside root.

---
 rtl/spi_reg_slave.sv | 187 ++++++++++++++++++
 tb/tb_spi_reg_slave.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI responder front end for the motor-controller register file.
// Each ss-framed transaction is 16 sclk cycles: a command byte {rw, addr, 3'b000}
// followed by a data byte, both MSB first. Writes become a single-cycle wr strobe
// and reads become a single-cycle rd strobe. For a read, the returned register
// value is shifted out on miso during the data byte. All SPI pins are
// oversampled in the clk domain, so clk must run at least 4x faster than sclk.
`timescale 1ns/1ps

module spi_reg_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  output logic              spioe,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wrdata,
  output logic              wr,
  output logic              rd,
  input  logic [DATA_W-1:0] rddata
);

  // One bit counter spans both bytes of the frame.
  localparam int CNT_W = $clog2(2 * DATA_W);
  localparam logic [CNT_W-1:0] LAST_CMD  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(2 * DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Pin synchronisers. These flops carry no reset: they follow the pins, and
  // leaving ss_dly untouched by reset means that a frame interrupted by reset
  // is not restarted until ss goes low and then high again.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_dly;
  logic                   ss_dly;

  // Shift each SPI pin through its synchroniser chain, plus one delay flop for edge detection.
  always_ff @(posedge clk) begin
    sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
    ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    sclk_dly  <= sclk_sync[SYNC_STAGES-1];
    ss_dly    <= ss_sync[SYNC_STAGES-1];
  end

  // ---------------------------------------------------------------------------
  // Edge qualification. sclk edges count only while synchronised ss is high,
  // so a host flush burst with ss low is invisible. ss falling in the same clk
  // as an sclk edge therefore also cancels that edge.
  // ---------------------------------------------------------------------------
  logic              sclk_s;
  logic              ss_s;
  logic              mosi_s;
  logic              sclk_rise;
  logic              sclk_fall;
  logic              ss_rise;
  logic [DATA_W-1:0] rx;
  logic [DATA_W-1:0] rx_next;

  // Derive the qualified edge events and the receive-register next value.
  always_comb begin
    sclk_s    = sclk_sync[SYNC_STAGES-1];
    ss_s      = ss_sync[SYNC_STAGES-1];
    mosi_s    = mosi_sync[SYNC_STAGES-1];
    sclk_rise = ss_s & sclk_s & ~sclk_dly;
    sclk_fall = ss_s & ~sclk_s & sclk_dly;
    ss_rise   = ss_s & ~ss_dly;
    rx_next   = {rx[DATA_W-2:0], mosi_s};
  end

  // ---------------------------------------------------------------------------
  // Transaction FSM and strobe generation.
  //  - cap marks the clk after rd; the register file's rddata is loaded into tx
  //    then. The inter-byte gap guarantees that this load happens before the
  //    first data-byte falling edge.
  //  - wr_pend delays wr by one clk, so addr/wrdata are already stable when wr
  //    rises.
  //  - rd, cap, wr_pend and wr are not cleared when ss drops. A strobe that has
  //    already been earned by a counted edge still completes.
  // ---------------------------------------------------------------------------
  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] tx;
  logic              rw;
  logic              cap;
  logic              wr_pend;

  // Single registered FSM: framing, bit counting, command decode, miso shift, strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rx      <= '0;
      tx      <= '0;
      rw      <= 1'b0;
      cap     <= 1'b0;
      wr_pend <= 1'b0;
      miso    <= 1'b0;
      spioe   <= 1'b0;
      addr    <= '0;
      wrdata  <= '0;
      wr      <= 1'b0;
      rd      <= 1'b0;
    end else begin
      rd      <= 1'b0;
      cap     <= rd;
      wr      <= wr_pend;
      wr_pend <= 1'b0;

      if (!ss_s) begin
        // Frame closed or aborted: drop back to idle and discard partial bits.
        state <= IDLE;
        cnt   <= '0;
        rx    <= '0;
        tx    <= '0;
        spioe <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (ss_rise) begin
              state <= CMD;
            end
          end

          CMD: begin
            if (sclk_rise) begin
              rx  <= rx_next;
              cnt <= cnt + 1'b1;
              if (cnt == LAST_CMD) begin
                state <= DATA;
                rw    <= rx_next[DATA_W-1];
                rd    <= rx_next[DATA_W-1];
                addr  <= rx_next[DATA_W-2 -: ADDR_W];
              end
            end
          end

          DATA: begin
            if (sclk_rise) begin
              rx  <= rx_next;
              cnt <= cnt + 1'b1;
              if (cnt == LAST_DATA) begin
                state <= DONE;
                if (!rw) begin
                  wrdata  <= rx_next;
                  wr_pend <= 1'b1;
                end
              end
            end

            if (cap) begin
              tx <= rddata;
            end else if (sclk_fall && rw) begin
              // Present the next bit for the host's following rising edge.
              spioe <= 1'b1;
              miso  <= tx[DATA_W-1];
              tx    <= {tx[DATA_W-2:0], 1'b0};
            end
          end

          DONE: begin
            // Extra host clocks are ignored; miso holds its last bit.
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_slave.sv
// Testbench for spi_reg_slave. A bit-banged SPI host drives directed and random
// transactions. Expected strobes are queued when each transaction is issued, and
// a monitor pops and compares them whenever the DUT raises wr or rd.
`timescale 1ns/1ps

module tb_spi_reg_slave;

  localparam int SYNC_STAGES = 2;
  localparam int ADDR_W      = 4;
  localparam int DATA_W      = 8;
  localparam int H           = 5;  // sclk half period in clk cycles
  localparam int GAP         = 6;  // extra clk between bytes

  logic              clk = 1'b0;
  logic              reset;
  logic              sclk;
  logic              ss;
  logic              mosi;
  logic              miso;
  logic              spioe;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wrdata;
  logic              wr;
  logic              rd;
  logic [DATA_W-1:0] rddata;

  // Reference register file: writes update it, reads are expected to return it.
  logic [DATA_W-1:0] regs_model [16];

  typedef struct packed {
    logic              is_wr;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   oe_prints = 0;
  bit   oe_allowed = 1'b0;

  always #5 clk = ~clk;

  // The register file answers the DUT combinationally from the model.
  assign rddata = regs_model[addr];

  spi_reg_slave #(
    .SYNC_STAGES(SYNC_STAGES),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sclk  (sclk),
    .ss    (ss),
    .mosi  (mosi),
    .miso  (miso),
    .spioe (spioe),
    .addr  (addr),
    .wrdata(wrdata),
    .wr    (wr),
    .rd    (rd),
    .rddata(rddata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Level seen by the host: the board pullup reads 1 when the DUT is not driving miso.
  function automatic logic miso_line();
    return spioe ? miso : 1'b1;
  endfunction

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every strobe must match the oldest expectation, and spioe must stay low outside read data windows.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (wr || rd) begin
      check("strobe_exclusive", {31'd0, wr & rd}, 32'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_strobe: wr=%0b rd=%0b addr=0x%0h wrdata=0x%0h, none expected",
                 wr, rd, addr, wrdata);
      end else begin
        e = exp_q.pop_front();
        check("strobe_kind_wr", {31'd0, wr}, {31'd0, e.is_wr});
        check("strobe_addr", {28'd0, addr}, {28'd0, e.a});
        if (e.is_wr) check("wrdata", {24'd0, wrdata}, {24'd0, e.d});
      end
    end
    if (!oe_allowed) begin
      n_cmp++;
      if (spioe) begin
        n_fail++;
        if (oe_prints < 5) begin
          oe_prints++;
          $display("FAIL spioe_window: got spioe=1, expected 0 outside read data at %0t", $time);
        end
      end
    end
  end

  // Host flush burst: eight sclk cycles with ss low.
  task automatic flush_burst();
    ss = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sclk = 1'b0;
      mosi = 1'($urandom);
      clks(H);
      sclk = 1'b1;
      clks(H);
    end
    clks(4);
  endtask

  // One host frame. nedges < 16 aborts after that many rising edges. extra adds
  // sclk cycles after the frame. reset_at > 0 pulses reset after that rising edge.
  task automatic xfer(input bit is_rd, input logic [3:0] a, input logic [7:0] d,
                      input int nedges, input int extra, input int reset_at);
    logic [15:0] frame;
    logic [7:0]  got;
    logic [7:0]  exp_rd;
    bit          full;
    frame  = {is_rd, a, 3'b000, is_rd ? 8'($urandom) : d};
    full   = (nedges == 16) && (reset_at == 0);
    got    = 8'h00;
    exp_rd = regs_model[a];
    if (is_rd && nedges >= 8 && (reset_at == 0 || reset_at > 8))
      exp_q.push_back('{is_wr: 1'b0, a: a, d: 8'h00});
    if (!is_rd && full) begin
      exp_q.push_back('{is_wr: 1'b1, a: a, d: d});
      regs_model[a] = d;
    end

    ss = 1'b1;
    clks(6);
    for (int i = 0; i < nedges; i++) begin
      if (i == 8) begin
        clks(GAP);
        if (is_rd) oe_allowed = 1'b1;
      end
      sclk = 1'b0;
      mosi = frame[15-i];
      clks(H);
      sclk = 1'b1;
      if (i >= 8 && is_rd && full) begin
        got[15-i] = miso_line();
        check("spioe_byte1", {31'd0, spioe}, 32'd1);
      end
      clks(H);
      if (reset_at != 0 && i + 1 == reset_at) begin
        reset = 1'b1;
        clks(1);
        check("reset_mid_outputs", {miso, spioe, addr, wrdata, wr, rd}, 32'd0);
        reset = 1'b0;
        clks(1);
      end
    end
    for (int i = 0; i < extra; i++) begin
      sclk = 1'b0;
      mosi = 1'($urandom);
      clks(H);
      sclk = 1'b1;
      clks(H);
    end
    ss = 1'b0;
    clks(SYNC_STAGES + 2);
    check("spioe_drop", {31'd0, spioe}, 32'd0);
    oe_allowed = 1'b0;
    clks(6);
    if (is_rd && full) check("rd_shift_in", {24'd0, got}, {24'd0, exp_rd});
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs_model[i] = 8'($urandom);
    sclk  = 1'b1;
    ss    = 1'b0;
    mosi  = 1'b0;
    reset = 1'b1;
    clks(5);
    check("reset_state", {miso, spioe, addr, wrdata, wr, rd}, 32'd0);
    reset = 1'b0;
    clks(3);

    // Two back-to-back writes.
    xfer(1'b0, 4'h2, 8'h00, 16, 0, 0);
    xfer(1'b0, 4'h0, 8'h40, 16, 0, 0);
    // Read of 0xF returning 0x04.
    regs_model[15] = 8'h04;
    xfer(1'b1, 4'hF, 8'h00, 16, 0, 0);
    // Flush bursts with ss low, then a write.
    flush_burst();
    flush_burst();
    xfer(1'b0, 4'hE, 8'h10, 16, 0, 0);
    // Write aborted after 12 edges, then a good write to the same address.
    xfer(1'b0, 4'hF, 8'h5A, 12, 0, 0);
    xfer(1'b0, 4'hF, 8'h80, 16, 0, 0);
    // Reset at edge 10 of a read, then a read of 0xD.
    xfer(1'b1, 4'h7, 8'h00, 16, 0, 10);
    xfer(1'b1, 4'hD, 8'h00, 16, 0, 0);
    // Write with four extra sclk cycles before ss drops.
    xfer(1'b0, 4'h0, 8'hC0, 16, 4, 0);

    // Random mix of reads, writes, aborts, extra clocks and flush bursts.
    for (int t = 0; t < 40; t++) begin
      bit   r;
      int   ne;
      if ($urandom_range(5) == 0) flush_burst();
      r  = 1'($urandom);
      ne = ($urandom_range(5) == 0) ? int'($urandom_range(15, 1)) : 16;
      xfer(r, 4'($urandom), 8'($urandom), ne, int'($urandom_range(3)), 0);
    end

    clks(10);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
